i2c_target: RTL and testbench

Single-address I2C target (responder) for the tag's digital core: the counterpart to the on-chip I2C initiator. It oversamples the open-drain SCL/SDA bus on the system clock, detects START/STOP, matches a 7-bit address, and ACKs. It bridges write and read transfers onto a byte-wide register port with an auto-incrementing pointer.

---
 rtl/i2c_target.sv | 197 +++++++++++++++++++
 tb/tb_i2c_target.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: single-address I2C target bridging the bus onto a byte-wide register port.
// Optional macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample filter on the synchronized SCL/SDA.
module i2c_target #(
   parameter logic [6:0] ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_wr,
   output logic       reg_rd,
   input  logic [7:0] reg_rdata,
   output logic       busy
);
   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ACK_A, S_WR_PTR, S_ACK_W, S_WR_DATA, S_RD_DATA, S_RD_MACK, S_IGNORE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  scl_sync_q, sda_sync_q;
   logic        scl_s, sda_s, scl_p_q, sda_p_q;
   logic [7:0]  sh_q, sh_d, ptr_q, ptr_d, wdata_q, wdata_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        oe_q, oe_d, wr_q, wr_d, rd_q, rd_d, rdcap_q, rnw_q, rnw_d, busy_q, busy_d;
   logic        scl_rise, scl_fall, start, stop, byte_done;
   logic [7:0]  rx_byte;

   // Idle bus level is high, so the synchronizers reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
      end
   end

`ifdef I2C_TGT_GLITCH_FILTER_EN
   logic [1:0] scl_h_q, sda_h_q;
   logic       scl_f_q, sda_f_q;

   // Output follows only when the current and two previous samples agree.
   assign scl_s = (scl_sync_q[1] == scl_h_q[0] && scl_h_q[0] == scl_h_q[1]) ? scl_sync_q[1] : scl_f_q;
   assign sda_s = (sda_sync_q[1] == sda_h_q[0] && sda_h_q[0] == sda_h_q[1]) ? sda_sync_q[1] : sda_f_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_h_q <= '1;
         sda_h_q <= '1;
         scl_f_q <= 1'b1;
         sda_f_q <= 1'b1;
      end else begin
         scl_h_q <= {scl_h_q[0], scl_sync_q[1]};
         sda_h_q <= {sda_h_q[0], sda_sync_q[1]};
         scl_f_q <= scl_s;
         sda_f_q <= sda_s;
      end
   end
`else
   assign scl_s = scl_sync_q[1];
   assign sda_s = sda_sync_q[1];
`endif

   // START/STOP require SCL high in both cycles, so a simultaneous SCL edge wins.
   assign scl_rise  = scl_s & ~scl_p_q;
   assign scl_fall  = ~scl_s & scl_p_q;
   assign start     = scl_s & scl_p_q & sda_p_q & ~sda_s;
   assign stop      = scl_s & scl_p_q & ~sda_p_q & sda_s;
   assign byte_done = (cnt_q == 4'd7);
   assign rx_byte   = {sh_q[6:0], sda_s};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) state_d = S_ADDR;
      else if (stop) state_d = S_IDLE;
      else begin
         case (state_q)
            S_ADDR:    if (scl_rise && byte_done) state_d = (rx_byte[7:1] == ADDR) ? S_ACK_A : S_IGNORE;
            S_WR_PTR,
            S_WR_DATA: if (scl_rise && byte_done) state_d = S_ACK_W;
            S_ACK_A:   if (scl_fall && oe_q) state_d = rnw_q ? S_RD_DATA : S_WR_PTR;
            S_ACK_W:   if (scl_fall && oe_q) state_d = S_WR_DATA;
            S_RD_DATA: if (scl_fall && cnt_q == 4'd8) state_d = S_RD_MACK;
            S_RD_MACK: if (scl_rise) state_d = sda_s ? S_IGNORE : S_RD_DATA;
            default:   ;
         endcase
      end
   end

   always_comb begin
      oe_d    = oe_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      rnw_d   = rnw_q;
      busy_d  = busy_q;
      if (wr_q || rdcap_q) ptr_d = ptr_q + 8'd1;
      if (rdcap_q) sh_d = reg_rdata;
      if (start) begin
         oe_d   = 1'b0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (stop) begin
         oe_d   = 1'b0;
         busy_d = 1'b0;
      end else begin
         case (state_q)
            S_ADDR, S_WR_PTR, S_WR_DATA: if (scl_rise) begin
               sh_d  = rx_byte;
               cnt_d = cnt_q + 4'd1;
               if (byte_done) begin
                  cnt_d = '0;
                  if (state_q == S_ADDR)   rnw_d = sda_s;
                  if (state_q == S_WR_PTR) ptr_d = rx_byte;
                  if (state_q == S_WR_DATA) begin
                     wr_d    = 1'b1;
                     wdata_d = rx_byte;
                  end
               end
            end
            S_ACK_A, S_ACK_W: begin
               if (scl_rise && oe_q && rnw_q && state_q == S_ACK_A) rd_d = 1'b1;
               if (scl_fall) begin
                  if (!oe_q) oe_d = 1'b1;
                  // Closing edge of a read ACK is also the first data-bit edge.
                  else if (state_q == S_ACK_A && rnw_q) begin
                     oe_d  = ~sh_q[7];
                     sh_d  = {sh_q[6:0], 1'b0};
                     cnt_d = 4'd1;
                  end else oe_d = 1'b0;
               end
            end
            S_RD_DATA: if (scl_fall) begin
               if (cnt_q == 4'd8) begin
                  oe_d  = 1'b0;
                  cnt_d = '0;
               end else begin
                  oe_d  = ~sh_q[7];
                  sh_d  = {sh_q[6:0], 1'b0};
                  cnt_d = cnt_q + 4'd1;
               end
            end
            S_RD_MACK: if (scl_rise && !sda_s) rd_d = 1'b1;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_p_q <= 1'b1;
         sda_p_q <= 1'b1;
         sh_q    <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         wdata_q <= '0;
         oe_q    <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rdcap_q <= 1'b0;
         rnw_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         scl_p_q <= scl_s;
         sda_p_q <= sda_s;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         oe_q    <= oe_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         rdcap_q <= rd_q;
         rnw_q   <= rnw_d;
         busy_q  <= busy_d;
      end
   end

   assign sda_oe    = oe_q & reset;
   assign reg_addr  = ptr_q;
   assign reg_wdata = wdata_q;
   assign reg_wr    = wr_q;
   assign reg_rd    = rd_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_i2c_target.sv
// Randomized bench for i2c_target: bit-level I2C master, transaction-level model and register-port scoreboard.
`timescale 1ns/1ps
module tb_i2c_target;
   localparam int unsigned Q = 8;

   typedef struct packed { logic is_wr; logic [7:0] addr; logic [7:0] data; } ev_t;

   logic       clk = 1'b0;
   logic       reset, scl_m, sda_m;
   logic       sda_bus, sda_oe, reg_wr, reg_rd, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic [7:0] rf [256];
   logic [7:0] ptr_m;
   ev_t        exp_q[$];
   ev_t        ev;
   int unsigned total = 0, bad = 0, oe_hi = 0, busy_hi = 0;

   always #5 clk = ~clk;
   assign sda_bus   = sda_m & ~sda_oe;
   assign reg_rdata = rf[reg_addr];

   i2c_target #(.ADDR(7'h50)) dut (
      .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic wq(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_x(input logic b, output logic s);
      wq(Q); sda_m = b; wq(Q); scl_m = 1'b1; wq(Q); s = sda_bus; wq(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      wq(Q); sda_m = 1'b1; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      wq(Q); sda_m = 1'b0; wq(Q); scl_m = 1'b1; wq(Q); sda_m = 1'b1; wq(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_x(b[i], s);
      bit_x(1'b1, s);
      ack = ~s;
   endtask

   task automatic rd_byte(output logic [7:0] b, input logic nack);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_x(1'b1, s);
         b[i] = s;
      end
      bit_x(nack, s);
   endtask

   // Model: each written byte lands at the pointer, which then advances mod 256.
   task automatic do_write(input logic [7:0] p, input int unsigned n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input bit send_stop);
      logic       ack;
      logic [7:0] d [3];
      d[0] = d0; d[1] = d1; d[2] = d2;
      i2c_start();
      check("busy_after_start", busy, 1);
      wr_byte(8'hA0, ack);
      check("addr_w_ack", ack, 1);
      wr_byte(p, ack);
      check("ptr_ack", ack, 1);
      ptr_m = p;
      for (int unsigned k = 0; k < n; k++) begin
         exp_q.push_back('{1'b1, ptr_m, d[k]});
         ptr_m++;
         wr_byte(d[k], ack);
         check("data_ack", ack, 1);
      end
      if (send_stop) begin
         i2c_stop();
         check("busy_after_stop", busy, 0);
      end
   endtask

   // Model: n bytes come from rf at successive pointer values, one register read each.
   task automatic do_read(input int unsigned n);
      logic       ack;
      logic [7:0] b, e, e_next;
      exp_q.push_back('{1'b0, ptr_m, 8'h00});
      e = rf[ptr_m];
      ptr_m++;
      e_next = e;
      i2c_start();
      wr_byte(8'hA1, ack);
      check("addr_r_ack", ack, 1);
      for (int unsigned k = 0; k < n; k++) begin
         if (k != n - 1) begin
            exp_q.push_back('{1'b0, ptr_m, 8'h00});
            e_next = rf[ptr_m];
            ptr_m++;
         end
         rd_byte(b, (k == n - 1));
         check("read_byte", b, e);
         e = e_next;
      end
      check("nack_release", sda_oe, 0);
      i2c_stop();
      check("busy_after_stop", busy, 0);
   endtask

   task automatic do_mismatch(input logic [7:0] a, input logic [7:0] d);
      logic        ack;
      int unsigned oe0;
      oe0 = oe_hi;
      i2c_start();
      wr_byte(a, ack);
      check("mismatch_addr_nack", ack, 0);
      wr_byte(d, ack);
      check("mismatch_data_nack", ack, 0);
      i2c_stop();
      check("mismatch_sda_oe", oe_hi - oe0, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        ack;
      logic [6:0]  ma;
      int unsigned b0;
      reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      ptr_m = 8'h00;
      for (int i = 0; i < 256; i++) rf[i] = 8'($urandom);
      rf[8'h20] = 8'h5A;
      rf[8'h21] = 8'h3C;

      fork
         forever begin
            @(negedge clk);
            if (sda_oe) oe_hi++;
            if (busy) busy_hi++;
            if (reg_wr || reg_rd) begin
               if (exp_q.size() == 0 || (reg_wr && reg_rd))
                  check("strobe_unexpected", {30'd0, reg_wr, reg_rd}, 32'd0);
               else begin
                  ev = exp_q.pop_front();
                  check(ev.is_wr ? "reg_wr_event" : "reg_rd_event",
                        {15'd0, reg_wr, reg_addr, reg_wr ? reg_wdata : 8'h00},
                        {15'd0, ev.is_wr, ev.addr, ev.is_wr ? ev.data : 8'h00});
               end
            end
         end
      join_none

      wq(5);
      check("reset_outputs", {14'd0, sda_oe, reg_wr, reg_rd, busy, reg_addr, reg_wdata}, 32'd0);
      reset = 1'b1;
      wq(5);

      do_write(8'h10, 2, 8'hAB, 8'hCD, 8'h00, 1'b1);
      do_write(8'h20, 0, 8'h00, 8'h00, 8'h00, 1'b0);
      do_read(2);
      do_mismatch(8'hB0, 8'h55);
      do_write(8'hFF, 2, 8'($urandom), 8'($urandom), 8'h00, 1'b1);
      check("ptr_model_wrap", ptr_m, 8'h01);
      do_read(1);

      // Reset while the target is driving a 0 data bit.
      do_write(8'h30, 0, 8'h00, 8'h00, 8'h00, 1'b1);
      rf[8'h30] = 8'h00;
      exp_q.push_back('{1'b0, 8'h30, 8'h00});
      i2c_start();
      wr_byte(8'hA1, ack);
      check("addr_r_ack", ack, 1);
      for (int i = 0; i < 40 && !sda_oe; i++) wq(1);
      check("read_bit_driven", sda_oe, 1);
      reset = 1'b0;
      #1;
      check("reset_sda_release", sda_oe, 0);
      check("reset_mid_outputs", {15'd0, reg_wr, reg_rd, busy, reg_addr, reg_wdata}, 32'd0);
      scl_m = 1'b1; sda_m = 1'b1;
      wq(4);
      reset = 1'b1;
      ptr_m = 8'h00;
      wq(4);
      scl_m = 1'b0;
      i2c_stop();
      check("stop_alone_busy", busy, 0);
      do_write(8'h40, 1, 8'($urandom), 8'h00, 8'h00, 1'b1);

      for (int it = 0; it < 12; it++) begin
         case ($urandom_range(0, 2))
            0: do_write(8'($urandom), $urandom_range(0, 3), 8'($urandom), 8'($urandom),
                        8'($urandom), 1'b1);
            1: do_read($urandom_range(1, 3));
            default: begin
               ma = 7'($urandom_range(0, 127));
               if (ma == 7'h50) ma = 7'h51;
               do_mismatch({ma, 1'($urandom)}, 8'($urandom));
            end
         endcase
      end

      // 1-clk SDA low pulse with SCL high.
      wq(Q);
      b0 = busy_hi;
      sda_m = 1'b0;
      wq(1);
      sda_m = 1'b1;
      wq(12);
`ifdef I2C_TGT_GLITCH_FILTER_EN
      check("glitch_start_seen", (busy_hi != b0), 0);
`else
      check("glitch_start_seen", (busy_hi != b0), 1);
`endif
      check("glitch_busy_after", busy, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
